fifo_row_packer: RTL and testbench
==================================

FIFO_ROW_PACKER -- requirements
Module: fifo_row_packer

Interface
REQ-001 Parameter: LANES, default 4, bytes packed per output word (supported value 4 only).
REQ-002 Parameter: DATA_W, default 8, width of one FIFO byte.
REQ-003 Port: clk  input  1  single clock; all state updates on posedge clk.
REQ-004 Port: rst  input  1  reset; asynchronous and active-high.
REQ-005 Port: fifo_dataout  input  8  byte from the upstream 8-bit sync FIFO; valid the cycle after a granted fifo_rd_en.
REQ-006 Port: fifo_empty  input  1  upstream FIFO empty flag (registered in FIFO).
REQ-007 Port: fifo_rd_en  output  1  pop request to the upstream FIFO.
REQ-008 Port: flush  input  1  single-cycle request to emit a partially filled word.
REQ-009 Port: out_data  output  32  packed word; lane k in bits [8k+7:8k].
REQ-010 Port: out_bytes  output  3  count of valid lanes in out_data, 1..4.
REQ-011 Port: out_valid  output  1  out_data/out_bytes valid.
REQ-012 Port: out_ready  input  1  downstream accepts the word when out_valid && out_ready.

Function
REQ-013 Two states SHALL exist: FILL (collecting bytes) and EMIT (holding a word); reset state FILL.
REQ-014 Internal registers SHALL be lane_cnt (0..4), pending (read issued, byte due next cycle), flush_req, and a 32-bit assembly register.
REQ-015 fifo_rd_en SHALL be combinational: 1 iff state==FILL, !rst, !fifo_empty, !flush_req, and lane_cnt+pending < 4.
REQ-016 pending SHALL be set on any cycle fifo_rd_en==1 and cleared otherwise.
REQ-017 When pending==1, fifo_dataout SHALL be written to assembly lane lane_cnt and lane_cnt incremented at that clock edge.
REQ-018 Back-to-back reads SHALL be issued: with ≥4 bytes in the FIFO, fifo_rd_en is high 4 consecutive cycles.
REQ-019 When the 4th byte is captured, out_data SHALL load the assembly value, out_bytes=4, out_valid=1, state=EMIT at that same edge; first fifo_rd_en to out_valid = 5 cycles.
REQ-020 In EMIT, out_data/out_bytes SHALL remain stable and fifo_rd_en SHALL be 0 until out_valid && out_ready.
REQ-021 On out_valid && out_ready: out_valid cleared, lane_cnt=0, assembly cleared, state=FILL at that edge; fifo_rd_en may assert the following cycle.
REQ-022 A flush pulse SHALL set flush_req in any state; flush_req blocks new reads.
REQ-023 In FILL with flush_req && !pending: if lane_cnt>0, out_data=assembly with unused lanes zero, out_bytes=lane_cnt, out_valid=1, state=EMIT; if lane_cnt==0, no output; flush_req cleared at that edge in both cases.
REQ-024 A flush arriving while pending==1 SHALL wait for that byte's capture, which is included in the flushed word.
REQ-025 A flush arriving in EMIT SHALL be serviced after return to FILL (applies to bytes captured later, possibly none).
REQ-026 fifo_empty going high SHALL stall reads without losing lane_cnt or assembly contents.

Reset
REQ-027 While rst==1: state=FILL, lane_cnt=0, pending=0, flush_req=0, assembly=0, out_data=0, out_bytes=0, out_valid=0, fifo_rd_en=0.
REQ-028 Reset mid-operation SHALL discard partial words and any in-flight byte (already popped from FIFO); no output follows.
REQ-029 First fifo_rd_en after reset release SHALL be no earlier than the first posedge with rst==0 and fifo_empty==0.

Verification
REQ-030 FIFO preloaded 0x11,0x22,0x33,0x44, out_ready=1 -> rd_en 4 consecutive cycles, out_data=0x44332211, out_bytes=4, out_valid 1 cycle, 5 cycles after first rd_en.
REQ-031 Same bytes, out_ready=0 for 10 cycles -> out_valid held, out_data stable 0x44332211, rd_en=0 throughout; word accepted when out_ready=1.
REQ-032 Bytes 0xA1,0xB2 then FIFO empty, flush pulse -> out_data=0x0000B2A1, out_bytes=2.
REQ-033 Flush issued the cycle the 3rd byte (0xC3 after 0xA1,0xB2) is pending -> out_data=0x00C3B2A1, out_bytes=3.
REQ-034 8 bytes 0x01..0x08 with out_ready toggling every cycle -> two words 0x04030201 then 0x08070605, no byte lost or duplicated.
REQ-035 rst asserted after 2 bytes captured and 1 pending -> all outputs 0 immediately; after release, next 4 bytes form a fresh word, old bytes absent.

Source files
------------

// File: rtl/fifo_row_packer.sv
// rtl/fifo_row_packer.sv - packs bytes from an 8-bit sync FIFO into 32-bit words with flush support
module fifo_row_packer #(
   parameter int LANES  = 4,
   parameter int DATA_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       fifo_dataout,
   input  logic                    fifo_empty,
   output logic                    fifo_rd_en,
   input  logic                    flush,
   output logic [LANES*DATA_W-1:0] out_data,
   output logic [2:0]              out_bytes,
   output logic                    out_valid,
   input  logic                    out_ready
);

   localparam int CNT_W  = 3;
   localparam int WORD_W = LANES * DATA_W;

   typedef enum logic {
      FILL = 1'b0,
      EMIT = 1'b1
   } state_t;

   state_t              state;
   state_t              state_next;

   // lane_cnt counts captured bytes; pending means a pop was granted last cycle
   // and its byte shows up on fifo_dataout this cycle.
   logic [CNT_W-1:0]    lane_cnt;
   logic                pending;
   logic                flush_req;
   logic [WORD_W-1:0]   assembly;
   logic [WORD_W-1:0]   assembly_next;

   logic                capture;
   logic                capture_last;
   logic                flush_fire;
   logic                flush_emit;
   logic                accept;

   // Next-state, pop request and datapath strobes.
   always_comb begin
      state_next    = state;
      fifo_rd_en    = 1'b0;
      capture       = pending;
      capture_last  = pending && (lane_cnt == CNT_W'(LANES - 1));
      // A flush only fires once the in-flight byte has landed, so it is included.
      flush_fire    = (state == FILL) && flush_req && !pending;
      flush_emit    = flush_fire && (lane_cnt != '0);
      accept        = (state == EMIT) && out_valid && out_ready;
      assembly_next = assembly;
      for (int k = 0; k < LANES; k++) begin
         if (lane_cnt == CNT_W'(k)) begin
            assembly_next[k*DATA_W +: DATA_W] = fifo_dataout;
         end
      end
      case (state)
         FILL: begin
            // Counting the in-flight byte keeps the pipeline from over-reading.
            if (!rst && !fifo_empty && !flush_req &&
                ((lane_cnt + CNT_W'(pending)) < CNT_W'(LANES))) begin
               fifo_rd_en = 1'b1;
            end
            if (capture_last || flush_emit) begin
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (accept) begin
               state_next = FILL;
            end
         end
         default: state_next = FILL;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FILL;
      end else begin
         state <= state_next;
      end
   end

   // Byte capture, word assembly, flush tracking and output holding register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_cnt  <= '0;
         pending   <= 1'b0;
         flush_req <= 1'b0;
         assembly  <= '0;
         out_data  <= '0;
         out_bytes <= '0;
         out_valid <= 1'b0;
      end else begin
         pending   <= fifo_rd_en;
         // A new pulse wins over clearing so a flush is never dropped.
         flush_req <= flush || (flush_req && !flush_fire);
         if (accept) begin
            out_valid <= 1'b0;
            lane_cnt  <= '0;
            assembly  <= '0;
         end else if (capture) begin
            assembly <= assembly_next;
            lane_cnt <= lane_cnt + CNT_W'(1);
            if (capture_last) begin
               out_data  <= assembly_next;
               out_bytes <= 3'(LANES);
               out_valid <= 1'b1;
            end
         end else if (flush_emit) begin
            // Lanes not yet written are still zero from the last clear.
            out_data  <= assembly;
            out_bytes <= lane_cnt;
            out_valid <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_fifo_row_packer.sv
// tb/tb_fifo_row_packer.sv - directed scoreboard bench for fifo_row_packer
module tb_fifo_row_packer;

   logic        clk;
   logic        rst;
   logic [7:0]  fifo_dataout = 8'h00;
   logic        fifo_empty;
   logic        fifo_rd_en;
   logic        flush;
   logic [31:0] out_data;
   logic [2:0]  out_bytes;
   logic        out_valid;
   logic        out_ready;

   fifo_row_packer #(.LANES(4), .DATA_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_dataout (fifo_dataout),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .flush        (flush),
      .out_data     (out_data),
      .out_bytes    (out_bytes),
      .out_valid    (out_valid),
      .out_ready    (out_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Upstream FIFO model: the bench writes via wr_ptr, the pop side owns rd_ptr.
   logic [7:0] mem [256];
   logic [7:0] wr_ptr = 8'd0;
   logic [7:0] rd_ptr = 8'd0;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_dataout <= mem[rd_ptr];
         rd_ptr       <= rd_ptr + 8'd1;
      end
   end

   // Accepted words, as {out_bytes, out_data}.
   logic [34:0] got_q [$];
   logic [34:0] exp_q [$];
   int          got_rd = 0;

   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         got_q.push_back({out_bytes, out_data});
      end
   end

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      mem[wr_ptr] = b;
      wr_ptr      = wr_ptr + 8'd1;
   endtask

   task automatic wait_drain(input int bound);
      for (int i = 0; i < bound && (got_q.size() - got_rd) < exp_q.size(); i++) begin
         cyc();
         #3;
      end
   endtask

   task automatic check_sb(input string tag);
      int n_got;
      n_got = got_q.size() - got_rd;
      chk({tag, "_count"}, 64'(n_got), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && got_rd < got_q.size(); i++) begin
         chk({tag, "_word"}, 64'(got_q[got_rd]), 64'(exp_q[i]));
         got_rd++;
      end
      got_rd = got_q.size();
      exp_q.delete();
   endtask

   logic [11:0] rd_hist;
   logic [11:0] ov_hist;
   int          n_rd;
   int          n_held;

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      out_ready = 1'b1;
      rd_hist   = '0;
      ov_hist   = '0;

      // Reset with data waiting: nothing may be requested or presented.
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      exp_q.push_back({3'd4, 32'h44332211});
      cyc(); #3;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_bytes", 64'(out_bytes), 64'd0);
      chk("rst_rd_en", 64'(fifo_rd_en), 64'd0);

      // Four back-to-back pops, word valid for one cycle, five cycles after first pop.
      cyc(); rst = 1'b0; #3;
      rd_hist[0] = fifo_rd_en;
      ov_hist[0] = out_valid;
      for (int i = 1; i < 12; i++) begin
         cyc(); #3;
         rd_hist[i] = fifo_rd_en;
         ov_hist[i] = out_valid;
      end
      chk("t1_rd_en_pattern", 64'(rd_hist), 64'h00F);
      chk("t1_valid_pattern", 64'(ov_hist), 64'h020);
      check_sb("t1_sb");

      // Backpressure: word held stable with no pops until accepted.
      cyc(); out_ready = 1'b0;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      exp_q.push_back({3'd4, 32'h44332211});
      #3;
      n_rd   = (fifo_rd_en === 1'b1) ? 1 : 0;
      n_held = 0;
      for (int i = 1; i < 15; i++) begin
         cyc(); #3;
         if (fifo_rd_en === 1'b1) n_rd++;
         if (i >= 5 && out_valid === 1'b1 && out_data === 32'h44332211 &&
             out_bytes === 3'd4 && fifo_rd_en === 1'b0) n_held++;
      end
      chk("t2_rd_en_count", 64'(n_rd), 64'd4);
      chk("t2_held_cycles", 64'(n_held), 64'd10);
      chk("t2_no_early_accept", 64'(got_q.size() - got_rd), 64'd0);
      cyc(); out_ready = 1'b1; #3;
      cyc(); #3;
      chk("t2_valid_cleared", 64'(out_valid), 64'd0);
      check_sb("t2_sb");

      // Partial word flushed after the FIFO runs dry.
      cyc(); push_byte(8'hA1); push_byte(8'hB2); #3;
      for (int i = 0; i < 6; i++) begin
         cyc(); #3;
      end
      chk("t3_no_output_before_flush", 64'(out_valid), 64'd0);
      cyc(); flush = 1'b1; #3;
      cyc(); flush = 1'b0; #3;
      exp_q.push_back({3'd2, 32'h0000B2A1});
      wait_drain(10);
      check_sb("t3_sb");

      // Flush while the third byte is in flight: that byte joins the word.
      cyc(); push_byte(8'hA1); push_byte(8'hB2); push_byte(8'hC3); #3;
      cyc(); #3;
      cyc(); #3;
      cyc(); flush = 1'b1; #3;
      cyc(); flush = 1'b0; #3;
      exp_q.push_back({3'd3, 32'h00C3B2A1});
      wait_drain(10);
      check_sb("t4_sb");

      // Flush with nothing collected produces no word.
      cyc(); flush = 1'b1; #3;
      cyc(); flush = 1'b0; #3;
      for (int i = 0; i < 5; i++) begin
         cyc(); #3;
      end
      check_sb("t4b_empty_flush");

      // Toggling out_ready: two words, no byte lost or duplicated.
      cyc(); out_ready = 1'b0;
      for (int b = 1; b <= 8; b++) push_byte(8'(b));
      exp_q.push_back({3'd4, 32'h04030201});
      exp_q.push_back({3'd4, 32'h08070605});
      #3;
      for (int i = 0; i < 40; i++) begin
         cyc(); out_ready = ~out_ready; #3;
      end
      cyc(); out_ready = 1'b1; #3;
      wait_drain(10);
      check_sb("t5_sb");

      // Reset with two bytes captured and one in flight: all of it is discarded.
      cyc();
      for (int b = 8'h61; b <= 8'h67; b++) push_byte(8'(b));
      #3;
      cyc(); #3;
      cyc(); #3;
      cyc(); rst = 1'b1; #3;
      chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
      chk("t6_rst_out_data", 64'(out_data), 64'd0);
      chk("t6_rst_out_bytes", 64'(out_bytes), 64'd0);
      chk("t6_rst_rd_en", 64'(fifo_rd_en), 64'd0);
      cyc(); #3;
      cyc(); rst = 1'b0; #3;
      exp_q.push_back({3'd4, 32'h67666564});
      wait_drain(20);
      for (int i = 0; i < 4; i++) begin
         cyc(); #3;
      end
      check_sb("t6_sb");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
